// File: rtl/pads_ctrl_if.sv
// Peripheral bus between the CPU and the pad controller: a held request
// answered by a one-cycle ack, with read data valid only alongside ack.
interface pads_ctrl_if #(
  parameter int NUMPADS = 8
);
  logic               req;
  logic               we;
  logic [3:0]         addr;
  logic [NUMPADS-1:0] wdata;
  logic               ack;
  logic [NUMPADS-1:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input  ack, input  rdata);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output ack, output rdata);
endinterface

// File: rtl/pads_ctrl.sv
// Pad ring controller: register-mapped per-pad controls, output-enable
// turnaround sequencing, and synchronized pad inputs with edge interrupts.
module pads_ctrl #(
  parameter int NUMPADS    = 8,
  parameter int TURNAROUND = 2
) (
  input  logic               clk,
  input  logic               rst,
  pads_ctrl_if.slave         bus,
  output logic               irq,
  output logic [NUMPADS-1:0] output_val,
  output logic [NUMPADS-1:0] output_en,
  output logic [NUMPADS-1:0] pullup_en,
  output logic [NUMPADS-1:0] pulldown_en,
  output logic [NUMPADS-1:0] slew_limit_en,
  output logic [NUMPADS-1:0] input_en,
  input  logic [NUMPADS-1:0] input_val
);

  localparam logic [3:0] A_OUT_VAL  = 4'd0;
  localparam logic [3:0] A_OUT_EN   = 4'd1;
  localparam logic [3:0] A_PULLUP   = 4'd2;
  localparam logic [3:0] A_PULLDOWN = 4'd3;
  localparam logic [3:0] A_SLEW     = 4'd4;
  localparam logic [3:0] A_IN_EN    = 4'd5;
  localparam logic [3:0] A_IN_VAL   = 4'd6;
  localparam logic [3:0] A_IRQ_MASK = 4'd7;
  localparam logic [3:0] A_IRQ_STAT = 4'd8;

  typedef enum logic [1:0] {IDLE, ACK, TURN} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [NUMPADS-1:0] pend_set;
  logic [NUMPADS-1:0] irq_mask;
  logic [NUMPADS-1:0] irq_stat;
  logic [NUMPADS-1:0] sync1;
  logic [NUMPADS-1:0] sync2;
  logic [NUMPADS-1:0] in_val;
  logic [NUMPADS-1:0] in_val_q;
  logic [NUMPADS-1:0] rise;
  logic [NUMPADS-1:0] new_bits;
  logic [NUMPADS-1:0] read_mux;

  assign in_val   = sync2 & input_en;
  assign rise     = in_val & ~in_val_q;
  assign new_bits = bus.wdata & ~output_en;
  assign irq      = |(irq_stat & irq_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= input_val;
      sync2 <= sync1;
    end
  end

  always_comb begin
    read_mux = '0;
    case (bus.addr)
      A_OUT_VAL:  read_mux = output_val;
      A_OUT_EN:   read_mux = output_en;
      A_PULLUP:   read_mux = pullup_en;
      A_PULLDOWN: read_mux = pulldown_en;
      A_SLEW:     read_mux = slew_limit_en;
      A_IN_EN:    read_mux = input_en;
      A_IN_VAL:   read_mux = in_val;
      A_IRQ_MASK: read_mux = irq_mask;
      A_IRQ_STAT: read_mux = irq_stat;
      default:    read_mux = '0;
    endcase
  end

  // Edge capture runs every cycle; a W1C clear on the same bit loses to a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pend_set      <= '0;
      bus.ack       <= 1'b0;
      bus.rdata     <= '0;
      output_val    <= '0;
      output_en     <= '0;
      pullup_en     <= '0;
      pulldown_en   <= '0;
      slew_limit_en <= '1;
      input_en      <= '0;
      irq_mask      <= '0;
      irq_stat      <= '0;
      in_val_q      <= '0;
    end else begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      in_val_q  <= in_val;
      irq_stat  <= irq_stat | rise;

      case (state)
        IDLE: begin
          if (bus.req) begin
            if (bus.we && bus.addr == A_OUT_EN && new_bits != '0) begin
              // Drop cleared enables now; newly-set ones wait out the turnaround.
              output_en <= output_en & bus.wdata;
              pend_set  <= new_bits;
              cnt       <= 4'(TURNAROUND);
              state     <= TURN;
            end else begin
              bus.ack <= 1'b1;
              state   <= ACK;
              if (!bus.we) begin
                bus.rdata <= read_mux;
              end else begin
                case (bus.addr)
                  A_OUT_VAL:  output_val <= bus.wdata;
                  A_OUT_EN:   output_en  <= bus.wdata;
                  A_PULLUP: begin
                    pullup_en   <= bus.wdata;
                    pulldown_en <= pulldown_en & ~bus.wdata;
                  end
                  A_PULLDOWN: begin
                    pulldown_en <= bus.wdata;
                    pullup_en   <= pullup_en & ~bus.wdata;
                  end
                  A_SLEW:     slew_limit_en <= bus.wdata;
                  A_IN_EN:    input_en      <= bus.wdata;
                  A_IRQ_MASK: irq_mask      <= bus.wdata;
                  A_IRQ_STAT: irq_stat      <= (irq_stat & ~bus.wdata) | rise;
                  default: ;
                endcase
              end
            end
          end
        end

        ACK: state <= IDLE;

        TURN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            output_en <= output_en | pend_set;
            bus.ack   <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pads_ctrl.sv
// Directed bench for pads_ctrl: register map, OUT_EN turnaround timing,
// pull exclusion, input edge interrupts and reset in the middle of a stall.
module tb_pads_ctrl;

  logic       clk;
  logic       rst;
  logic       irq;
  logic [7:0] output_val, output_en, pullup_en, pulldown_en, slew_limit_en, input_en;
  logic [7:0] input_val;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rd;
  int         lat;

  pads_ctrl_if #(.NUMPADS(8)) bus_if ();

  pads_ctrl #(.NUMPADS(8), .TURNAROUND(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if.slave),
    .irq           (irq),
    .output_val    (output_val),
    .output_en     (output_en),
    .pullup_en     (pullup_en),
    .pulldown_en   (pulldown_en),
    .slew_limit_en (slew_limit_en),
    .input_en      (input_en),
    .input_val     (input_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One bus access starting from a known-idle cycle; lat counts edges from acceptance to ack.
  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [7:0] d,
                               output logic [7:0] rdat, output int latency);
    @(posedge clk); #1;
    bus_if.req   = 1'b1;
    bus_if.we    = w;
    bus_if.addr  = a;
    bus_if.wdata = d;
    latency = -1;
    rdat    = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus_if.ack) begin
        latency = k;
        rdat    = bus_if.rdata;
        break;
      end
    end
    bus_if.req = 1'b0;
    bus_if.we  = 1'b0;
  endtask

  // OUT_EN write that sets new bits, stepped edge by edge with TURNAROUND = 2.
  task automatic turnAccess(input logic [7:0] d, input logic [7:0] exp_drop, input logic [7:0] exp_final);
    @(posedge clk); #1;
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = 4'd1;
    bus_if.wdata = d;
    @(posedge clk); #1;
    checkOutput("turn_drop_en", output_en, exp_drop);
    checkOutput("turn_ack_low1", bus_if.ack, 0);
    checkOutput("turn_outval_ready", output_val, 8'h0F);
    @(posedge clk); #1;
    checkOutput("turn_hold_en", output_en, exp_drop);
    checkOutput("turn_ack_low2", bus_if.ack, 0);
    @(posedge clk); #1;
    checkOutput("turn_rise_en", output_en, exp_final);
    checkOutput("turn_ack", bus_if.ack, 1);
    bus_if.req = 1'b0;
    bus_if.we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    input_val    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_irq", irq, 0);
    checkOutput("rst_ack", bus_if.ack, 0);
    checkOutput("rst_rdata_idle", bus_if.rdata, 0);
    checkOutput("rst_slew_pin", slew_limit_en, 8'hFF);
    checkOutput("rst_outen_pin", output_en, 0);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 4'(a), 8'h00, rd, lat);
      checkOutput($sformatf("rst_read_%0d", a), rd, (a == 4) ? 8'hFF : 8'h00);
      checkOutput($sformatf("rst_lat_%0d", a), lat, 1);
    end
    @(posedge clk); #1;
    checkOutput("rdata_after_ack", bus_if.rdata, 0);

    $display("[TB] output enable turnaround");
    applyStimulus(1'b1, 4'd0, 8'h0F, rd, lat);
    checkOutput("outval_lat", lat, 1);
    checkOutput("outval_pin", output_val, 8'h0F);
    checkOutput("outen_still_off", output_en, 0);
    turnAccess(8'h0F, 8'h00, 8'h0F);
    turnAccess(8'h30, 8'h00, 8'h30);
    applyStimulus(1'b1, 4'd1, 8'h10, rd, lat);
    checkOutput("outen_clear_only_lat", lat, 1);
    checkOutput("outen_clear_only_pin", output_en, 8'h10);
    applyStimulus(1'b1, 4'd1, 8'h30, rd, lat);
    checkOutput("outen_reset_lat", lat, 3);
    checkOutput("outen_reset_pin", output_en, 8'h30);

    $display("[TB] pull exclusion");
    applyStimulus(1'b1, 4'd2, 8'hFF, rd, lat);
    applyStimulus(1'b1, 4'd3, 8'h03, rd, lat);
    applyStimulus(1'b0, 4'd2, 8'h00, rd, lat);
    checkOutput("pullup_read", rd, 8'hFC);
    applyStimulus(1'b0, 4'd3, 8'h00, rd, lat);
    checkOutput("pulldown_read", rd, 8'h03);
    checkOutput("pull_overlap", pullup_en & pulldown_en, 0);
    applyStimulus(1'b1, 4'd2, 8'h01, rd, lat);
    checkOutput("pullup_pin", pullup_en, 8'h01);
    checkOutput("pulldown_pin", pulldown_en, 8'h02);

    $display("[TB] unmapped and misc registers");
    applyStimulus(1'b1, 4'd12, 8'hFF, rd, lat);
    checkOutput("unmapped_wr_lat", lat, 1);
    applyStimulus(1'b0, 4'd12, 8'h00, rd, lat);
    checkOutput("unmapped_read", rd, 0);
    applyStimulus(1'b1, 4'd4, 8'h5A, rd, lat);
    checkOutput("slew_pin", slew_limit_en, 8'h5A);

    $display("[TB] input edge interrupt");
    applyStimulus(1'b1, 4'd5, 8'h01, rd, lat);
    applyStimulus(1'b1, 4'd7, 8'h01, rd, lat);
    input_val = 8'h03;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("irq_not_yet", irq, 0);
    @(posedge clk); #1;
    checkOutput("irq_rise", irq, 1);
    applyStimulus(1'b0, 4'd6, 8'h00, rd, lat);
    checkOutput("in_val_masked_by_en", rd, 8'h01);
    applyStimulus(1'b0, 4'd8, 8'h00, rd, lat);
    checkOutput("irq_stat_read", rd, 8'h01);
    applyStimulus(1'b1, 4'd8, 8'h01, rd, lat);
    applyStimulus(1'b0, 4'd8, 8'h00, rd, lat);
    checkOutput("irq_stat_w1c", rd, 8'h00);
    checkOutput("irq_cleared", irq, 0);
    input_val = 8'h00;
    repeat (4) @(posedge clk);
    #1 input_val = 8'h01;
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'd8, 8'h01, rd, lat);
    applyStimulus(1'b0, 4'd8, 8'h00, rd, lat);
    checkOutput("irq_stat_set_wins", rd, 8'h01);
    checkOutput("irq_set_wins", irq, 1);
    applyStimulus(1'b1, 4'd7, 8'h00, rd, lat);
    checkOutput("irq_masked", irq, 0);

    $display("[TB] reset during turnaround");
    @(posedge clk); #1;
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = 4'd1;
    bus_if.wdata = 8'hC0;
    @(posedge clk); #1;
    checkOutput("pre_rst_stall", bus_if.ack, 0);
    rst        = 1'b1;
    bus_if.req = 1'b0;
    bus_if.we  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_outen", output_en, 0);
    checkOutput("midrst_outval", output_val, 0);
    checkOutput("midrst_slew", slew_limit_en, 8'hFF);
    checkOutput("midrst_pullup", pullup_en, 0);
    checkOutput("midrst_inen", input_en, 0);
    checkOutput("midrst_irq", irq, 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("midrst_no_ack_%0d", k), bus_if.ack, 0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 4'd1, 8'h00, rd, lat);
    checkOutput("midrst_read_outen", rd, 0);
    checkOutput("midrst_read_lat", lat, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
